// File: rtl/inst_dispatch_feeder_pkg.sv
// Shared definitions for the R10K instruction dispatch feeder.
// Holds the default core width / address width, the RV32 opcodes the
// feeder decodes, the HALT (WFI) encoding and the dispatch packet layout.

`ifndef N_WAY
`define N_WAY 3
`endif

package inst_dispatch_feeder_pkg;

    localparam int N_WAY           = `N_WAY;
    localparam int XLEN            = 32;
    localparam int EX_BRANCH_UNITS = 1;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // WFI is used as the program terminator
    localparam logic [31:0] INST_HALT = 32'h10500073;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [4:0]      src1;
        logic [4:0]      src2;
        logic [4:0]      dest;
        logic            valid;
    } DISPATCH_PACKET_R10K;

endpackage

// File: rtl/dispatch_lane_decode.sv
// Per-lane instruction decode for the dispatch feeder.
// Ports:
//   inst      in   32  raw instruction word
//   src1      out  5   rs1 field
//   src2      out  5   rs2 field
//   dest      out  5   rd field, zero for instructions without a destination
//   is_branch out  1   conditional branch, JAL or JALR
//   is_halt   out  1   instruction is the HALT (WFI) terminator

module dispatch_lane_decode
    import inst_dispatch_feeder_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  src1,
    output logic [4:0]  src2,
    output logic [4:0]  dest,
    output logic        is_branch,
    output logic        is_halt
);

    logic [6:0] opcode;

    assign opcode = inst[6:0];
    assign src1   = inst[19:15];
    assign src2   = inst[24:20];

    // Stores and branches reuse bits [11:7] as immediate, not a register
    assign dest = ((opcode == OP_STORE) || (opcode == OP_BRANCH)) ? 5'd0 : inst[11:7];

    assign is_branch = (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_halt   = (inst == INST_HALT);

endmodule

// File: rtl/inst_dispatch_feeder.sv
// Front-end instruction feeder for the N-way R10K out-of-order core.
// Presents up to N_WAY in-order decoded packets per cycle from the program
// image, advances by the number of lanes accepted, predicts not-taken and
// redirects on a branch hazard.
// Ports:
//   clock        in   1                       rising-edge clock
//   reset        in   1                       asynchronous, active-high
//   dispatched   in   N_WAY                   per-lane accept (prefix mask)
//   branch_haz   in   1                       redirect request
//   br_result    in   EX_BRANCH_UNITS x XLEN  redirect targets, entry 0 used
//   branch_inst  out  N_WAY                   lane holds a valid branch/jump
//   dispatch_out out  N_WAY x packet          {inst, pc, src1, src2, dest, valid}

module inst_dispatch_feeder
    import inst_dispatch_feeder_pkg::*;
#(
    parameter int    N_WAY           = inst_dispatch_feeder_pkg::N_WAY,
    parameter int    XLEN            = inst_dispatch_feeder_pkg::XLEN,
    parameter int    EX_BRANCH_UNITS = inst_dispatch_feeder_pkg::EX_BRANCH_UNITS,
    parameter int    MEM_WORDS       = 1024,
    parameter string PROG_FILE       = "program.mem"
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [N_WAY-1:0]                           dispatched,
    input  logic                                       branch_haz,
    input  logic [EX_BRANCH_UNITS-1:0][XLEN-1:0]       br_result,
    output logic [N_WAY-1:0]                           branch_inst,
    output DISPATCH_PACKET_R10K [N_WAY-1:0]            dispatch_out
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int KW = $clog2(N_WAY + 1);

    logic [XLEN-1:0] pc;
    logic            halted;

    logic [31:0] mem [MEM_WORDS];

    logic [N_WAY-1:0][31:0]     lane_inst;
    logic [N_WAY-1:0][XLEN-1:0] lane_pc;
    logic [N_WAY-1:0][4:0]      lane_src1;
    logic [N_WAY-1:0][4:0]      lane_src2;
    logic [N_WAY-1:0][4:0]      lane_dest;
    logic [N_WAY-1:0]           in_range;
    logic [N_WAY-1:0]           is_br;
    logic [N_WAY-1:0]           is_halt;
    logic [N_WAY-1:0]           valid;

    logic [KW-1:0]   accept_cnt;
    logic            halt_taken;
    logic [XLEN-1:0] halt_pc;

    for (genvar i = 0; i < N_WAY; i++) begin : g_lane
        logic [XLEN-1:0] widx;

        // Word index cannot overflow: pc>>2 leaves two spare high bits
        assign widx         = XLEN'(pc >> 2) + XLEN'(i);
        assign in_range[i]  = (widx < XLEN'(MEM_WORDS));
        assign lane_inst[i] = in_range[i] ? mem[widx[AW-1:0]] : 32'd0;
        assign lane_pc[i]   = pc + (XLEN'(i) << 2);

        dispatch_lane_decode u_dec (
            .inst      (lane_inst[i]),
            .src1      (lane_src1[i]),
            .src2      (lane_src2[i]),
            .dest      (lane_dest[i]),
            .is_branch (is_br[i]),
            .is_halt   (is_halt[i])
        );

        assign dispatch_out[i] = valid[i] ?
            '{inst: lane_inst[i], pc: lane_pc[i], src1: lane_src1[i],
              src2: lane_src2[i], dest: lane_dest[i], valid: 1'b1} : '0;
        assign branch_inst[i] = valid[i] & is_br[i];
    end

    // A lane is offered only if every earlier lane is offered and none of
    // them ends the group (branch: not-taken prediction, one per group; HALT).
    always_comb begin
        logic chain_ok;
        chain_ok = !reset && !halted && !branch_haz;
        for (int i = 0; i < N_WAY; i++) begin
            valid[i] = chain_ok && in_range[i];
            chain_ok = valid[i] && !is_br[i] && !is_halt[i];
        end
    end

    // Accept count is the run of leading lanes that are both valid and taken;
    // anything after the first gap is ignored.
    always_comb begin
        logic run;
        run        = 1'b1;
        accept_cnt = '0;
        halt_taken = 1'b0;
        halt_pc    = '0;
        for (int i = 0; i < N_WAY; i++) begin
            run = run & dispatched[i] & valid[i];
            if (run) begin
                accept_cnt = accept_cnt + KW'(1);
                if (is_halt[i]) begin
                    halt_taken = 1'b1;
                    halt_pc    = lane_pc[i];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc     <= '0;
            halted <= 1'b0;
        end else if (branch_haz) begin
            pc     <= br_result[0] & ~XLEN'(3);
            halted <= 1'b0;
        end else if (accept_cnt != '0) begin
            if (halt_taken) begin
                // Park on the HALT itself so a redirect is the only way out
                pc     <= halt_pc;
                halted <= 1'b1;
            end else begin
                pc <= pc + (XLEN'(accept_cnt) << 2);
            end
        end
    end

endmodule

// File: tb/tb_inst_dispatch_feeder.sv
module tb_inst_dispatch_feeder;
    import inst_dispatch_feeder_pkg::*;

    localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_BEQ  = 32'h00208463; // beq x1,x2,+8
    localparam logic [31:0] I_HALT = 32'h10500073; // wfi

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic [2:0]                dispatched = 3'b000;
    logic                      branch_haz = 1'b0;
    logic [0:0][31:0]          br_result = '0;
    logic [2:0]                branch_inst;
    DISPATCH_PACKET_R10K [2:0] dispatch_out;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    inst_dispatch_feeder #(
        .N_WAY(3), .XLEN(32), .EX_BRANCH_UNITS(1), .MEM_WORDS(1024), .PROG_FILE("")
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dispatched   (dispatched),
        .branch_haz   (branch_haz),
        .br_result    (br_result),
        .branch_inst  (branch_inst),
        .dispatch_out (dispatch_out)
    );

    function automatic logic [2:0] vbits();
        return {dispatch_out[2].valid, dispatch_out[1].valid, dispatch_out[0].valid};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; dispatched = 3'b000; branch_haz = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        dispatched = 3'b111;
        #1;
        total++; if (vbits() !== 3'b000) begin $display("FAIL reset_valid got=%b exp=%b", vbits(), 3'b000); bad++; end
        total++; if (branch_inst !== 3'b000) begin $display("FAIL reset_brinst got=%b exp=%b", branch_inst, 3'b000); bad++; end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_straight_line();
        total++; if (vbits() !== 3'b111) begin $display("FAIL sl_valid0 got=%b exp=%b", vbits(), 3'b111); bad++; end
        total++; if (dispatch_out[0].pc !== 32'h0) begin $display("FAIL sl_pc0 got=%h exp=%h", dispatch_out[0].pc, 32'h0); bad++; end
        total++; if (dispatch_out[1].pc !== 32'h4) begin $display("FAIL sl_pc1 got=%h exp=%h", dispatch_out[1].pc, 32'h4); bad++; end
        total++; if (dispatch_out[2].pc !== 32'h8) begin $display("FAIL sl_pc2 got=%h exp=%h", dispatch_out[2].pc, 32'h8); bad++; end
        total++; if (dispatch_out[0].inst !== I_ADD) begin $display("FAIL sl_inst got=%h exp=%h", dispatch_out[0].inst, I_ADD); bad++; end
        total++; if ({dispatch_out[0].src1, dispatch_out[0].src2, dispatch_out[0].dest} !== {5'd1, 5'd2, 5'd3})
            begin $display("FAIL sl_decode got=%0d/%0d/%0d exp=1/2/3", dispatch_out[0].src1, dispatch_out[0].src2, dispatch_out[0].dest); bad++; end
        step();
        total++; if (dispatch_out[0].pc !== 32'hC) begin $display("FAIL sl_pc0_next got=%h exp=%h", dispatch_out[0].pc, 32'hC); bad++; end
        total++; if (dispatch_out[2].pc !== 32'h14) begin $display("FAIL sl_pc2_next got=%h exp=%h", dispatch_out[2].pc, 32'h14); bad++; end
    endtask

    task automatic test_partial_accept();
        step();                       // 12 -> 24
        dispatched = 3'b011;
        #1;
        total++; if (dispatch_out[0].pc !== 32'h18) begin $display("FAIL pa_start got=%h exp=%h", dispatch_out[0].pc, 32'h18); bad++; end
        step();                       // 24 + 8
        total++; if (dispatch_out[0].pc !== 32'h20) begin $display("FAIL pa_011 got=%h exp=%h", dispatch_out[0].pc, 32'h20); bad++; end
        dispatched = 3'b101;
        step();                       // only lane 0 counts
        total++; if (dispatch_out[0].pc !== 32'h24) begin $display("FAIL pa_101 got=%h exp=%h", dispatch_out[0].pc, 32'h24); bad++; end
        dispatched = 3'b000;
        step(); step();
        total++; if (dispatch_out[0].pc !== 32'h24) begin $display("FAIL pa_stall_pc got=%h exp=%h", dispatch_out[0].pc, 32'h24); bad++; end
        total++; if (vbits() !== 3'b111) begin $display("FAIL pa_stall_valid got=%b exp=%b", vbits(), 3'b111); bad++; end
    endtask

    task automatic test_redirect();
        branch_haz = 1'b1; br_result[0] = 32'h40; dispatched = 3'b111;
        #1;
        total++; if (vbits() !== 3'b000) begin $display("FAIL rd_haz_valid got=%b exp=%b", vbits(), 3'b000); bad++; end
        total++; if (branch_inst !== 3'b000) begin $display("FAIL rd_haz_brinst got=%b exp=%b", branch_inst, 3'b000); bad++; end
        step();
        branch_haz = 1'b0; dispatched = 3'b000;
        #1;
        total++; if (dispatch_out[0].pc !== 32'h40) begin $display("FAIL rd_target got=%h exp=%h", dispatch_out[0].pc, 32'h40); bad++; end
    endtask

    task automatic test_branch_group();
        total++; if (vbits() !== 3'b011) begin $display("FAIL bg_valid got=%b exp=%b", vbits(), 3'b011); bad++; end
        total++; if (branch_inst !== 3'b010) begin $display("FAIL bg_brinst got=%b exp=%b", branch_inst, 3'b010); bad++; end
        total++; if (dispatch_out[1].dest !== 5'd0) begin $display("FAIL bg_dest got=%0d exp=0", dispatch_out[1].dest); bad++; end
        total++; if (dispatch_out[1].src2 !== 5'd2) begin $display("FAIL bg_src2 got=%0d exp=2", dispatch_out[1].src2); bad++; end
        total++; if (dispatch_out[2] !== '0) begin $display("FAIL bg_lane2_zero got=%h exp=0", dispatch_out[2]); bad++; end
        dispatched = 3'b111;
        step();
        total++; if (dispatch_out[0].pc !== 32'h48) begin $display("FAIL bg_after got=%h exp=%h", dispatch_out[0].pc, 32'h48); bad++; end
    endtask

    task automatic test_halt();
        dispatched = 3'b000;
        #1;
        total++; if (vbits() !== 3'b011) begin $display("FAIL ht_valid got=%b exp=%b", vbits(), 3'b011); bad++; end
        total++; if (dispatch_out[1].inst !== I_HALT) begin $display("FAIL ht_inst got=%h exp=%h", dispatch_out[1].inst, I_HALT); bad++; end
        total++; if (branch_inst !== 3'b000) begin $display("FAIL ht_brinst got=%b exp=%b", branch_inst, 3'b000); bad++; end
        dispatched = 3'b111;
        step();
        total++; if (vbits() !== 3'b000) begin $display("FAIL ht_halted got=%b exp=%b", vbits(), 3'b000); bad++; end
        step();
        total++; if (vbits() !== 3'b000) begin $display("FAIL ht_stays got=%b exp=%b", vbits(), 3'b000); bad++; end
        branch_haz = 1'b1; br_result[0] = 32'h0;
        step();
        branch_haz = 1'b0; dispatched = 3'b000;
        #1;
        total++; if (vbits() !== 3'b111) begin $display("FAIL ht_resume_valid got=%b exp=%b", vbits(), 3'b111); bad++; end
        total++; if (dispatch_out[0].pc !== 32'h0) begin $display("FAIL ht_resume_pc got=%h exp=%h", dispatch_out[0].pc, 32'h0); bad++; end
    endtask

    task automatic test_reset_mid();
        dispatched = 3'b111;
        step(); step();               // 0 -> 12 -> 24
        dispatched = 3'b011;
        step();                       // 24 -> 32
        dispatched = 3'b000;
        #1;
        total++; if (dispatch_out[0].pc !== 32'h20) begin $display("FAIL rm_pc got=%h exp=%h", dispatch_out[0].pc, 32'h20); bad++; end
        reset = 1'b1;
        #1;
        total++; if (vbits() !== 3'b000) begin $display("FAIL rm_valid got=%b exp=%b", vbits(), 3'b000); bad++; end
        step();
        reset = 1'b0;
        #1;
        total++; if (dispatch_out[0].pc !== 32'h0) begin $display("FAIL rm_pc0 got=%h exp=%h", dispatch_out[0].pc, 32'h0); bad++; end
        total++; if (vbits() !== 3'b111) begin $display("FAIL rm_valid_after got=%b exp=%b", vbits(), 3'b111); bad++; end
    endtask

    task automatic test_mem_edge();
        branch_haz = 1'b1; br_result[0] = 32'h0000_0FFE; // low bits dropped
        step();
        branch_haz = 1'b0; dispatched = 3'b111;
        #1;
        total++; if (dispatch_out[0].pc !== 32'hFFC) begin $display("FAIL me_pc got=%h exp=%h", dispatch_out[0].pc, 32'hFFC); bad++; end
        total++; if (vbits() !== 3'b001) begin $display("FAIL me_valid got=%b exp=%b", vbits(), 3'b001); bad++; end
        step();                       // only one valid lane accepted
        total++; if (vbits() !== 3'b000) begin $display("FAIL me_beyond got=%b exp=%b", vbits(), 3'b000); bad++; end
        dispatched = 3'b000;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) dut.mem[i] = I_ADD;
        dut.mem[17] = I_BEQ;
        dut.mem[19] = I_HALT;

        test_reset();
        test_straight_line();
        test_partial_accept();
        test_redirect();
        test_branch_group();
        test_halt();
        test_reset_mid();
        test_mem_edge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
